// File: rtl/byte_queue_multipop.sv
// In-order queue of W-bit entries: single push, NPOP-wide head window, multi-entry retire, in-place patch.
// Latency: pushed or patched entries appear on top_data one cycle after the edge; all outputs come from registers.
// Backpressure: push_ready drops when full, even if a pop lands in the same cycle; the producer retries.
module byte_queue_multipop #(
    parameter int W     = 8,
    parameter int DEPTH = 5,
    parameter int NPOP  = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(NPOP + 1),
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [W-1:0]      push_data,
    output logic              push_ready,
    input  logic [PW-1:0]     pop_cnt,
    output logic [NPOP*W-1:0] top_data,
    output logic [NPOP-1:0]   top_valid,
    input  logic              patch_en,
    input  logic [IW-1:0]     patch_idx,
    input  logic [W-1:0]      patch_data,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              err_under,
    output logic              err_patch
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [W-1:0]  patched [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          err_under_q, err_under_d;
    logic          err_patch_q, err_patch_d;

    logic          push_fire;
    logic          patch_ok;
    int            cnt_i;
    int            pop_i;
    int            idx_i;
    int            pop_eff;
    int            r_i;

    assign push_ready = (count_q < CW'(DEPTH));
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign err_under  = err_under_q;
    assign err_patch  = err_patch_q;

    // Entry 0 is always the head; every event indexes the pre-edge contents.
    always_comb begin
        cnt_i       = int'(count_q);
        pop_i       = int'(pop_cnt);
        idx_i       = int'(patch_idx);
        patch_ok    = patch_en && (idx_i < cnt_i);
        pop_eff     = (pop_i > NPOP) ? NPOP : pop_i;
        r_i         = (pop_eff > cnt_i) ? cnt_i : pop_eff;
        push_fire   = push_valid && push_ready;
        err_under_d = (pop_i > cnt_i) || (pop_i > NPOP);
        err_patch_d = patch_en && !patch_ok;

        for (int i = 0; i < DEPTH; i++) begin
            patched[i] = (patch_ok && (idx_i == i)) ? patch_data : mem_q[i];
        end

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
        end
        for (int s = 0; s <= NPOP; s++) begin
            if (r_i == s) begin
                for (int i = 0; i < DEPTH - s; i++) begin
                    mem_d[i] = patched[i + s];
                end
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (push_fire && (i == cnt_i - r_i)) begin
                mem_d[i] = push_data;
            end
        end

        count_d = CW'(cnt_i - r_i + (push_fire ? 1 : 0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q     <= '0;
            err_under_q <= 1'b0;
            err_patch_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count_q     <= count_d;
            err_under_q <= err_under_d;
            err_patch_q <= err_patch_d;
        end
    end

    // Slots past the occupancy are masked so stale storage never leaks out.
    always_comb begin
        top_data  = '0;
        top_valid = '0;
        for (int k = 0; k < NPOP; k++) begin
            if (k < int'(count_q)) begin
                top_data[(NPOP-k)*W-1 -: W] = mem_q[k];
                top_valid[k]                = 1'b1;
            end
        end
    end

endmodule
